// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - state encodings and control constants for the multi-cycle RV32 controller
// The TRAP state exists only when RISCV_MC_ILLEGAL_TRAP_EN is defined.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC_R = 4'd7,
    ST_EXEC_I = 4'd8,
    ST_ALUWB  = 4'd9,
    ST_BRANCH = 4'd10
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    , ST_TRAP = 4'd11
`endif
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;

  // DECODE dispatch; the caller chooses where unknown opcodes go.
  function automatic state_e dispatch(input logic [6:0] opc, input state_e unknown_next);
    state_e nxt;
    nxt = unknown_next;
    case (opc)
      OPC_LOAD, OPC_STORE: nxt = ST_MEMADR;
      OPC_RTYPE:           nxt = ST_EXEC_R;
      OPC_ITYPE:           nxt = ST_EXEC_I;
      OPC_BRANCH:          nxt = ST_BRANCH;
      default:             nxt = unknown_next;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/riscv_mc_out_decode.sv
// rtl/riscv_mc_out_decode.sv - combinational state to control-word decode for the multi-cycle controller
// Adds illegal_op_o when RISCV_MC_ILLEGAL_TRAP_EN is defined.
module riscv_mc_out_decode
  import riscv_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  input  logic [2:0] funct3_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] result_src_o
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op_o
`endif
);

  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_RS2;
    alu_op_o     = ALUOP_ADD;
    result_src_o = RES_ALUOUT;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    illegal_op_o = 1'b0;
`endif
    case (state_i)
      ST_FETCH: begin
        // IR and PC+4 are captured only in the cycle the memory completes.
        mem_req_o    = 1'b1;
        adr_src_o    = 1'b0;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_FOUR;
        alu_op_o     = ALUOP_ADD;
        result_src_o = RES_ALU;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      ST_DECODE: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALUOP_ADD;
      end
      ST_MEMADR, ST_EXEC_I: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
      end
      ST_MEMWB: begin
        reg_write_o  = 1'b1;
        result_src_o = RES_MEMDATA;
      end
      ST_MEMWR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        adr_src_o = 1'b1;
      end
      ST_EXEC_R: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_RS2;
        alu_op_o    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        reg_write_o  = 1'b1;
        result_src_o = RES_ALUOUT;
      end
      ST_BRANCH: begin
        alu_src_a_o  = SRCA_RS1;
        alu_src_b_o  = SRCB_RS2;
        alu_op_o     = ALUOP_SUB;
        result_src_o = RES_ALUOUT;
        pc_write_o   = zero_i && (funct3_i == F3_BEQ);
      end
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
      ST_TRAP: illegal_op_o = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// rtl/riscv_multicycle_ctrl.sv - main control FSM and retired-instruction counter of the multi-cycle RV32 core
// Define RISCV_MC_ILLEGAL_TRAP_EN to send unknown opcodes to an absorbing TRAP state with illegal_op.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         result_src,
  output logic [CNT_W-1:0]   instret,
  output logic [3:0]         state_o
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
  ,
  output logic               illegal_op
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [1:0]       alu_op_w;
  logic             retire;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
      ST_DECODE: state_d = dispatch(opcode, ST_TRAP);
      ST_TRAP:   state_d = ST_TRAP;
`else
      ST_DECODE: state_d = dispatch(opcode, ST_FETCH);
`endif
      ST_MEMADR: state_d = (opcode == OPC_LOAD) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
      ST_EXEC_R: state_d = ST_ALUWB;
      ST_EXEC_I: state_d = ST_ALUWB;
      ST_ALUWB:  state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Only completed instructions count; the unknown-opcode DECODE->FETCH path does not.
  always_comb begin
    retire = 1'b0;
    if (state_d == ST_FETCH) begin
      case (state_q)
        ST_MEMWB, ST_MEMWR, ST_ALUWB, ST_BRANCH: retire = 1'b1;
        default:                                 retire = 1'b0;
      endcase
    end
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  riscv_mc_out_decode u_out_decode (
    .state_i      (state_q),
    .mem_ready_i  (mem_ready),
    .zero_i       (zero),
    .funct3_i     (funct3),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .adr_src_o    (adr_src),
    .ir_write_o   (ir_write),
    .pc_write_o   (pc_write),
    .reg_write_o  (reg_write),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op_w),
    .result_src_o (result_src)
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    ,
    .illegal_op_o (illegal_op)
`endif
  );

  assign alu_op  = ALUOP_W'(alu_op_w);
  assign instret = instret_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb/tb_riscv_multicycle_ctrl.sv - self-checking bench for riscv_multicycle_ctrl using per-instruction expected traces
// Honours RISCV_MC_ILLEGAL_TRAP_EN; a second instance with CNT_W=4 covers counter wrap.
module tb_riscv_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [31:0] instret;
  logic [3:0]  state_o;
  logic        mem_req4, mem_we4, adr_src4, ir_write4, pc_write4, reg_write4;
  logic [1:0]  alu_src_a4, alu_src_b4, alu_op4, result_src4;
  logic [3:0]  instret4;
  logic [3:0]  state4;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
  logic        illegal_op, illegal_op4;
`endif

  riscv_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .instret(instret), .state_o(state_o)
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  riscv_multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req4), .mem_we(mem_we4), .adr_src(adr_src4), .ir_write(ir_write4), .pc_write(pc_write4),
    .reg_write(reg_write4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op(alu_op4),
    .result_src(result_src4), .instret(instret4), .state_o(state4)
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op4)
`endif
  );

  always #5 clk = ~clk;

  logic [13:0] word, word4;
  assign word  = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, alu_op, result_src};
  assign word4 = {mem_req4, mem_we4, adr_src4, ir_write4, pc_write4, reg_write4,
                  alu_src_a4, alu_src_b4, alu_op4, result_src4};

  typedef struct {
    state_e      st;
    logic        mr;
    logic [13:0] w;
    logic        ill;
  } step_t;

  step_t       trace[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned exp_cnt = 0;

  function automatic logic [13:0] mk(input logic mreq, input logic mwe, input logic adr,
                                     input logic irw, input logic pcw, input logic rgw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] op, input logic [1:0] rs);
    return {mreq, mwe, adr, irw, pcw, rgw, a, b, op, rs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_step(input step_t s);
    string n;
    n = s.st.name();
    chk({"state@", n}, 32'(state_o), 32'(s.st));
    chk({"ctrl@", n}, 32'(word), 32'(s.w));
    chk({"instret@", n}, instret, exp_cnt);
    chk({"state4@", n}, 32'(state4), 32'(s.st));
    chk({"ctrl4@", n}, 32'(word4), 32'(s.w));
    chk({"instret4@", n}, 32'(instret4), exp_cnt % 16);
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    chk({"illegal_op@", n}, 32'(illegal_op), 32'(s.ill));
    chk({"illegal_op4@", n}, 32'(illegal_op4), 32'(s.ill));
`endif
  endtask

  task automatic push(input state_e st, input logic mr, input logic [13:0] w, input logic ill);
    step_t s;
    s.st = st; s.mr = mr; s.w = w; s.ill = ill;
    trace.push_back(s);
  endtask

  // Reset asserted at the previous negedge: one edge later the core must be idle and cleared.
  task automatic reset_tail();
    step_t idle;
    idle.st = ST_IDLE; idle.mr = 1'b0; idle.w = '0; idle.ill = 1'b0;
    @(negedge clk);
    mem_ready = 1'($urandom);
    #1;
    exp_cnt = 0;
    check_step(idle);
    rst_n = 1'b1;
    #1;
    check_step(idle);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    reset_tail();
  endtask

  // Builds the expected cycle-by-cycle trace of one instruction, drives it and checks every cycle.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                           input int fw, input int mw, input int abort_at);
    bit retire;
    bit trapped;
    retire = 1'b1;
    trapped = 1'b0;
    trace.delete();
    repeat (fw) push(ST_FETCH, 1'b0, mk(1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10), 1'b0);
    push(ST_FETCH, 1'b1, mk(1,0,0,1,1,0,2'b00,2'b10,2'b00,2'b10), 1'b0);
    push(ST_DECODE, 1'($urandom), mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00), 1'b0);
    case (opc)
      OPC_RTYPE: begin
        push(ST_EXEC_R, 1'($urandom), mk(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00), 1'b0);
        push(ST_ALUWB, 1'($urandom), mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00), 1'b0);
      end
      OPC_ITYPE: begin
        push(ST_EXEC_I, 1'($urandom), mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00), 1'b0);
        push(ST_ALUWB, 1'($urandom), mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00), 1'b0);
      end
      OPC_LOAD: begin
        push(ST_MEMADR, 1'($urandom), mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00), 1'b0);
        repeat (mw) push(ST_MEMRD, 1'b0, mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00), 1'b0);
        push(ST_MEMRD, 1'b1, mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00), 1'b0);
        push(ST_MEMWB, 1'($urandom), mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01), 1'b0);
      end
      OPC_STORE: begin
        push(ST_MEMADR, 1'($urandom), mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00), 1'b0);
        repeat (mw) push(ST_MEMWR, 1'b0, mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00), 1'b0);
        push(ST_MEMWR, 1'b1, mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00), 1'b0);
      end
      OPC_BRANCH: begin
        push(ST_BRANCH, 1'($urandom),
             mk(0,0,0,0,z && (f3 == 3'b000),0,2'b10,2'b00,2'b01,2'b00), 1'b0);
      end
      default: begin
        retire = 1'b0;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
        trapped = 1'b1;
        repeat (4) push(ST_TRAP, 1'($urandom), 14'd0, 1'b1);
`endif
      end
    endcase
    foreach (trace[i]) begin
      @(negedge clk);
      if (i == abort_at) rst_n = 1'b0;
      mem_ready = trace[i].mr;
      opcode = (trace[i].st == ST_FETCH) ? 7'($urandom) : opc;
      funct3 = (trace[i].st == ST_FETCH) ? 3'($urandom) : f3;
      zero   = (trace[i].st == ST_BRANCH) ? z : 1'($urandom);
      #1;
      check_step(trace[i]);
      if (i == abort_at) begin
        reset_tail();
        return;
      end
    end
    if (retire) exp_cnt++;
    if (trapped) do_reset();
  endtask

  function automatic logic [6:0] rand_opcode();
    logic [6:0] o;
    case ($urandom_range(0, 5))
      0: o = OPC_LOAD;
      1: o = OPC_STORE;
      2: o = OPC_RTYPE;
      3: o = OPC_ITYPE;
      4: o = OPC_BRANCH;
      default: begin
        do o = 7'($urandom);
        while (o == OPC_LOAD || o == OPC_STORE || o == OPC_RTYPE || o == OPC_ITYPE || o == OPC_BRANCH);
      end
    endcase
    return o;
  endfunction

  initial begin
    do_reset();
    run_instr(OPC_RTYPE, 3'b000, 1'b0, 0, 0, -1);
    run_instr(OPC_LOAD, 3'b010, 1'b0, 0, 3, -1);
    run_instr(OPC_BRANCH, 3'b000, 1'b1, 1, 0, -1);
    run_instr(OPC_BRANCH, 3'b000, 1'b0, 0, 0, -1);
    run_instr(OPC_BRANCH, 3'b001, 1'b1, 0, 0, -1);
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, -1);
    run_instr(OPC_STORE, 3'b010, 1'b0, 2, 1, -1);
    run_instr(OPC_STORE, 3'b010, 1'b0, 0, 5, 4);
    for (int k = 0; k < 18; k++)
      run_instr(OPC_ITYPE, 3'($urandom), 1'($urandom), $urandom_range(0, 1), 0, -1);
    for (int k = 0; k < 60; k++)
      run_instr(rand_opcode(), 3'($urandom_range(0, 1) == 0 ? 0 : $urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3), -1);
    @(negedge clk);
    #1;
    chk("final_instret", instret, exp_cnt);
    chk("final_instret4", 32'(instret4), exp_cnt % 16);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
